// File: rtl/ji_pkg.sv
// ============================================================================
//  Module   : ji_pkg
//  Purpose  : Shared widths, opcodes, state and entry types for the JI packer.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package ji_pkg;

    localparam int OPW    = 5;
    localparam int FIELDW = 27;
    localparam int WORDW  = 32;

    localparam logic [OPW-1:0] OP_J   = 5'b00001;
    localparam logic [OPW-1:0] OP_JAL = 5'b00011;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } pack_state_t;

    typedef struct packed {
        logic [OPW-1:0]    opcode;
        logic [FIELDW-1:0] field;
        logic              ovf;
    } entry_t;

endpackage

`default_nettype wire

// File: rtl/s_fit32_27.sv
// ============================================================================
//  Module   : s_fit32_27
//  Purpose  : Narrows a 32-bit signed target to a 27-bit field and flags fit.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module s_fit32_27
    import ji_pkg::*;
(
    input  logic [WORDW-1:0]  in,
    output logic [FIELDW-1:0] field,
    output logic              fits
);

    logic [WORDW-FIELDW:0] w_top;

    // The dropped bits plus the field's sign bit must all agree.
    assign w_top = in[WORDW-1:FIELDW-1];
    assign field = in[FIELDW-1:0];
    assign fits  = (&w_top) | ~(|w_top);

endmodule

`default_nettype wire

// File: rtl/ji_target_packer.sv
// ============================================================================
//  Module   : ji_target_packer
//  Purpose  : Packs opcode + narrowed target into a JI word; 2-entry skid stage.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module ji_target_packer #(
    parameter int OPW    = ji_pkg::OPW,
    parameter int FIELDW = ji_pkg::FIELDW,
    parameter int WORDW  = ji_pkg::WORDW,
    parameter int CNTW   = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OPW-1:0]   in_opcode,
    input  logic [WORDW-1:0] in_target,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WORDW-1:0] out_insn,
    output logic             out_ovf,
    output logic [CNTW-1:0]  ovf_count
);

    import ji_pkg::*;

    pack_state_t       state_q;
    entry_t            o_q;
    entry_t            s_q;
    logic              in_ready_q;
    logic              out_valid_q;
    logic [CNTW-1:0]   cnt_q;

    logic [FIELDW-1:0] w_field;
    logic              w_fits;
    logic              w_accept;
    logic              w_xfer;
    entry_t            w_new;

    s_fit32_27 u_fit (
        .in    (in_target),
        .field (w_field),
        .fits  (w_fits)
    );

    assign w_accept = in_valid && in_ready_q;
    assign w_xfer   = out_valid_q && out_ready;
    assign w_new    = '{opcode: in_opcode, field: w_field, ovf: !w_fits};

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_EMPTY;
            o_q         <= '0;
            s_q         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            if (w_accept && !w_fits && (cnt_q != {CNTW{1'b1}})) begin
                cnt_q <= cnt_q + 1'b1;
            end
            case (state_q)
                ST_EMPTY: begin
                    if (w_accept) begin
                        o_q         <= w_new;
                        state_q     <= ST_ONE;
                        out_valid_q <= 1'b1;
                    end
                end
                ST_ONE: begin
                    if (w_accept && w_xfer) begin
                        o_q <= w_new;
                    end else if (w_accept) begin
                        s_q        <= w_new;
                        state_q    <= ST_TWO;
                        in_ready_q <= 1'b0;
                    end else if (w_xfer) begin
                        state_q     <= ST_EMPTY;
                        out_valid_q <= 1'b0;
                    end
                end
                ST_TWO: begin
                    // Ready is low here, so only the drain of S can happen.
                    if (w_xfer) begin
                        o_q        <= s_q;
                        state_q    <= ST_ONE;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= ST_EMPTY;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Ready is forced low while reset is held so no beat is taken during it.
    assign in_ready  = in_ready_q && !reset;
    assign out_valid = out_valid_q;
    assign out_insn  = {o_q.opcode, o_q.field};
    assign out_ovf   = o_q.ovf;
    assign ovf_count = cnt_q;

endmodule

`default_nettype wire
